// File: rtl/cordiv_ctrl.sv
// ============================================================================
//  Module      : cordiv_ctrl
//  Description : Sequencer for one stochastic division on a CORDIV unit.
//                Builds correlated operand streams from one shared LFSR and
//                counts the quotient ones into a binary result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordiv_ctrl #(
    parameter int               WIDTH   = 8,
    parameter int               SRDEPTH = 2,
    parameter int               SELW    = $clog2(SRDEPTH),
    parameter logic [WIDTH-1:0] SEED    = 8'h01,
    parameter logic [15:0]      SSEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_val,
    input  logic [WIDTH-1:0] divisor_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             div_clr,
    output logic             div_en,
    output logic             div_dividend,
    output logic             div_divisor,
    output logic [SELW-1:0]  div_sel,
    input  logic             div_quotient
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Feedback masks for a right-shifting Fibonacci LFSR: bit (WIDTH-e) for each
    // polynomial exponent e, so the x^WIDTH term lands on bit 0.
    function automatic logic [31:0] op_taps(input int w);
        case (w)
            3, 4, 6, 7, 15: op_taps = 32'h0000_0003;
            5:              op_taps = 32'h0000_0005;
            9:              op_taps = 32'h0000_0011;
            10:             op_taps = 32'h0000_0009;
            11:             op_taps = 32'h0000_0005;
            12:             op_taps = 32'h0000_0941;
            13:             op_taps = 32'h0000_1601;
            14:             op_taps = 32'h0000_2A01;
            16:             op_taps = 32'h0000_100B;
            default:        op_taps = 32'h0000_001D;
        endcase
    endfunction

    localparam logic [31:0]      c_OP_TAPS_FULL = op_taps(WIDTH);
    localparam logic [WIDTH-1:0] c_OP_TAPS      = c_OP_TAPS_FULL[WIDTH-1:0];
    localparam logic [15:0]      c_SEL_TAPS     = 16'h002D;
    localparam logic [WIDTH-1:0] c_LAST_CYC     = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] c_ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [15:0]      sel_lfsr_q, sel_lfsr_d;
    logic [WIDTH-1:0] cyc_q, cyc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clr_q, clr_d;
    logic             en_q, en_d;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_count_sat;

    assign w_sum       = {1'b0, count_q} + {{WIDTH{1'b0}}, div_quotient};
    assign w_count_sat = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        lfsr_d     = lfsr_q;
        sel_lfsr_d = sel_lfsr_q;
        cyc_d      = cyc_q;
        count_d    = count_q;
        result_d   = result_q;
        busy_d     = busy_q;
        err_d      = err_q;
        en_d       = en_q;
        done_d     = 1'b0;
        clr_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dividend_d = dividend_val;
                    divisor_d  = divisor_val;
                    clr_d      = 1'b1;
                    lfsr_d     = SEED;
                    sel_lfsr_d = SSEED;
                    count_d    = '0;
                    cyc_d      = '0;
                    result_d   = '0;
                    err_d      = 1'b0;
                    if (divisor_val == '0) begin
                        // Nothing to stream: report the error straight away.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        en_d    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                lfsr_d     = {^(lfsr_q & c_OP_TAPS), lfsr_q[WIDTH-1:1]};
                sel_lfsr_d = {^(sel_lfsr_q & c_SEL_TAPS), sel_lfsr_q[15:1]};
                count_d    = w_count_sat;
                cyc_d      = cyc_q + c_ONE;
                if (cyc_q == c_LAST_CYC) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    en_d     = 1'b0;
                    done_d   = 1'b1;
                    result_d = w_count_sat;
                    err_d    = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            lfsr_q     <= SEED;
            sel_lfsr_q <= SSEED;
            cyc_q      <= '0;
            count_q    <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clr_q      <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            lfsr_q     <= lfsr_d;
            sel_lfsr_q <= sel_lfsr_d;
            cyc_q      <= cyc_d;
            count_q    <= count_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            clr_q      <= clr_d;
            en_q       <= en_d;
        end
    end

    // en_q is high exactly in RUN, so it gates the streams to zero elsewhere.
    assign div_dividend = en_q & (dividend_q >= lfsr_q);
    assign div_divisor  = en_q & (divisor_q >= lfsr_q);
    assign div_sel      = en_q ? sel_lfsr_q[SELW-1:0] : '0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign err     = err_q;
    assign div_clr = clr_q;
    assign div_en  = en_q;

endmodule

`default_nettype wire

// File: tb/tb_cordiv_ctrl.sv
// ============================================================================
//  Module      : tb_cordiv_ctrl
//  Description : Directed self-checking bench for cordiv_ctrl with a
//                behavioural two-deep CORDIV divider attached.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cordiv_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend_val;
    logic [7:0] divisor_val;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err;
    logic       div_clr;
    logic       div_en;
    logic       div_dividend;
    logic       div_divisor;
    logic [0:0] div_sel;
    logic       div_quotient;

    always #5 clk = ~clk;

    cordiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dividend_val (dividend_val),
        .divisor_val  (divisor_val),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .err          (err),
        .div_clr      (div_clr),
        .div_en       (div_en),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_sel      (div_sel),
        .div_quotient (div_quotient)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural CORDIV: pass the dividend while the divisor bit is 1,
    // otherwise replay a stored dividend bit picked by div_sel.
    logic [1:0] sr = 2'b00;
    int m_q  = 0;
    int m_dd = 0;
    int m_dv = 0;
    int m_en = 0;

    assign div_quotient = div_divisor ? div_dividend : sr[div_sel];

    always @(posedge clk) begin
        if (div_clr === 1'b1)
            sr <= 2'b00;
        else if (div_en === 1'b1 && div_divisor === 1'b1)
            sr <= {sr[0], div_dividend};
        if (div_clr === 1'b1 || div_en === 1'b1) begin
            m_q  <= (div_clr === 1'b1 ? 0 : m_q)  + ((div_en === 1'b1) ? int'(div_quotient) : 0);
            m_dd <= (div_clr === 1'b1 ? 0 : m_dd) + ((div_en === 1'b1) ? int'(div_dividend) : 0);
            m_dv <= (div_clr === 1'b1 ? 0 : m_dv) + ((div_en === 1'b1) ? int'(div_divisor) : 0);
            m_en <= (div_clr === 1'b1 ? 0 : m_en) + ((div_en === 1'b1) ? 1 : 0);
        end
    end

    // Independent LFSR model: x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1.
    logic [7:0]  mr = 8'h01;
    logic [15:0] ms = 16'hACE1;
    logic [7:0]  op_a = 8'h00;
    logic [7:0]  op_b = 8'h00;

    always @(negedge clk) begin
        logic [7:0]  r;
        logic [15:0] s;
        r = (div_clr === 1'b1) ? 8'h01 : mr;
        s = (div_clr === 1'b1) ? 16'hACE1 : ms;
        if (div_en === 1'b1) begin
            chk("dividend_bit", {31'd0, div_dividend}, {31'd0, op_a >= r});
            chk("divisor_bit",  {31'd0, div_divisor},  {31'd0, op_b >= r});
            chk("sel_bit",      {31'd0, div_sel},      {31'd0, s[0]});
            mr <= {r[0] ^ r[2] ^ r[3] ^ r[4], r[7:1]};
            ms <= {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end else if (rst === 1'b0) begin
            chk("idle_streams", {29'd0, div_dividend, div_divisor, div_sel}, 32'd0);
            mr <= r;
            ms <= s;
        end
    end

    typedef struct {
        logic [7:0] res;
        logic       err;
        bit         rng;
        int         lat;
    } exp_t;

    exp_t sb[$];

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic exp_err, input bit rng,
                         input int p1, input int p2, input int rst_at);
        exp_t e;
        int   done_cyc;
        int   busy_cyc;
        bit   was_rst;
        done_cyc = -1;
        busy_cyc = 0;
        was_rst  = 1'b0;
        sb.push_back('{res: exp_res, err: exp_err, rng: rng, lat: (b == 8'd0) ? 1 : 256});

        @(negedge clk);
        dividend_val = a;
        divisor_val  = b;
        op_a         = a;
        op_b         = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (busy === 1'b1) busy_cyc++;
            if (c == p1 || c == p2) begin
                start        = 1'b1;
                dividend_val = ~a;
                divisor_val  = 8'd1;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("rst_busy",   {31'd0, busy},   32'd0);
                chk("rst_result", {24'd0, result}, 32'd0);
                chk("rst_div_en", {31'd0, div_en}, 32'd0);
                was_rst = 1'b1;
                break;
            end
        end
        start = 1'b0;

        e = sb.pop_front();
        if (was_rst) return;
        if (done_cyc < 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            return;
        end
        chk("done_cycle", done_cyc, e.lat);
        chk("busy_cycles", busy_cyc, e.lat - 1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("err", {31'd0, err}, {31'd0, e.err});
        if (e.rng)
            chk("result_range", {31'd0, (result >= 8'd116 && result <= 8'd140)}, 32'd1);
        else
            chk("result", {24'd0, result}, {24'd0, e.res});
        if (!e.err)
            chk("result_vs_model", {24'd0, result}, m_q);
        // A single done pulse and no queued restart afterwards.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("post_done_idle", {30'd0, busy, done}, 32'd0);
        end
        chk("result_held", {24'd0, result}, m_q > 255 ? 32'd255 : (e.err ? 32'd0 : m_q));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b1;
        dividend_val = 8'd33;
        divisor_val  = 8'd44;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {31'd0, busy},    32'd0);
        chk("reset_done",   {31'd0, done},    32'd0);
        chk("reset_err",    {31'd0, err},     32'd0);
        chk("reset_result", {24'd0, result},  32'd0);
        chk("reset_clr",    {31'd0, div_clr}, 32'd0);
        chk("reset_en",     {31'd0, div_en},  32'd0);
        chk("reset_streams", {29'd0, div_dividend, div_divisor, div_sel}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_op(8'd100, 8'd255, 8'd100, 1'b0, 1'b0, -1, -1, -1);
        chk("t1_dividend_ones", m_dd, 100);
        chk("t1_en_cycles", m_en, 255);

        do_op(8'd0, 8'd77, 8'd0, 1'b0, 1'b0, -1, -1, -1);
        chk("t2_dividend_ones", m_dd, 0);

        do_op(8'd200, 8'd200, 8'd255, 1'b0, 1'b0, -1, -1, -1);
        chk("t3_divisor_ones", m_dv, 200);

        do_op(8'd50, 8'd0, 8'd0, 1'b1, 1'b0, -1, -1, -1);
        chk("t4_en_cycles", m_en, 0);

        do_op(8'd100, 8'd255, 8'd100, 1'b0, 1'b0, 10, 255, -1);

        do_op(8'd64, 8'd128, 8'd0, 1'b0, 1'b1, -1, -1, 120);
        do_op(8'd64, 8'd128, 8'd0, 1'b0, 1'b1, -1, -1, -1);
        chk("t6_dividend_ones", m_dd, 64);
        chk("t6_divisor_ones", m_dv, 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
